// File: rtl/stopwatch_set_ctrl.sv
// Front-panel time-set controller: debounces three buttons and issues per-digit set strobes.
// Optional display blink is built only when STOPWATCH_SET_BLINK_EN is defined.
module stopwatch_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BLINK_CYCLES    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_confirm,
    output logic       run_en,
    output logic       set,
    output logic [5:0] select,
    output logic [3:0] digit_value,
    output logic [2:0] edit_idx,
    output logic       blink
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {StRun, StEdit, StCommit, StCommitExit} state_e;

    // Button vector bit order: 0 = inc, 1 = mode, 2 = confirm.
    logic [2:0]     raw;
    logic [2:0]     sync1_q, sync2_q, level_q, press_q;
    logic [DbW-1:0] cnt_q [3];

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] val_q, val_d;

    assign raw = {btn_confirm, btn_mode, btn_inc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_q[i]   <= '0;
                    level_q[i] <= sync2_q[i];
                    press_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    function automatic logic [3:0] digit_max(input logic [2:0] idx);
        case (idx)
            3'd1, 3'd3: digit_max = 4'd5;
            3'd5:       digit_max = 4'd2;
            default:    digit_max = 4'd9;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        val_d   = val_q;
        case (state_q)
            StRun: begin
                if (press_q[1]) begin
                    state_d = StEdit;
                    idx_d   = 3'd5;
                    val_d   = '0;
                end
            end
            StEdit: begin
                if (press_q[2]) begin
                    state_d = StCommitExit;
                end else if (press_q[1]) begin
                    state_d = StCommit;
                end else if (press_q[0]) begin
                    val_d = (val_q >= digit_max(idx_q)) ? 4'd0 : val_q + 4'd1;
                end
            end
            StCommit: begin
                if (idx_q == 3'd0) begin
                    state_d = StRun;
                end else begin
                    state_d = StEdit;
                    idx_d   = idx_q - 3'd1;
                    val_d   = '0;
                end
            end
            StCommitExit: state_d = StRun;
            default:      state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            idx_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
        end
    end

    assign run_en      = (state_q == StRun);
    assign set         = (state_q == StCommit) || (state_q == StCommitExit);
    assign select      = set ? (6'b000001 << idx_q) : 6'b000000;
    assign digit_value = val_q;
    assign edit_idx    = idx_q;

`ifdef STOPWATCH_SET_BLINK_EN
    localparam int unsigned BlW = $clog2(BLINK_CYCLES);

    logic           blink_q, blink_d;
    logic [BlW-1:0] blink_cnt_q, blink_cnt_d;
    logic           inc_in_edit;

    // Only an inc press that actually wins priority restarts the phase.
    assign inc_in_edit = (state_q == StEdit) && press_q[0] && !press_q[1] && !press_q[2];

    always_comb begin
        blink_d     = 1'b0;
        blink_cnt_d = '0;
        if (state_d == StEdit) begin
            if (state_q != StEdit || inc_in_edit) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BlW'(BLINK_CYCLES - 1)) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_set_ctrl.sv
// Self-checking bench for stopwatch_set_ctrl: directed test-plan steps plus random presses
// checked against an abstract digit-editing model.
module tb_stopwatch_set_ctrl;

    localparam int unsigned DEB   = 4;
    localparam int unsigned BLINK = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode, btn_inc, btn_confirm;
    logic       run_en, set, blink;
    logic [5:0] select;
    logic [3:0] digit_value;
    logic [2:0] edit_idx;

    int checks   = 0;
    int failures = 0;

    // Abstract model: editing flag, current digit, current value.
    int m_edit, m_idx, m_val;
    int maxes [6] = '{9, 5, 9, 5, 9, 2};

    int n_set, got_sel, got_val;
    int walk [6] = '{2, 3, 5, 9, 5, 9};
    int masks [6] = '{1, 2, 4, 6, 3, 7};

    stopwatch_set_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES   (BLINK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_confirm(btn_confirm),
        .run_en     (run_en),
        .set        (set),
        .select     (select),
        .digit_value(digit_value),
        .edit_idx   (edit_idx),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_run_en"}, 32'(run_en), 32'(m_edit == 0));
        chk({tag, "_edit_idx"}, 32'(edit_idx), 32'(m_idx));
        chk({tag, "_digit_value"}, 32'(digit_value), 32'(m_val));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            {btn_confirm, btn_mode, btn_inc} = 3'($urandom);
            tick();
            chk("reset_no_set", 32'(set), 32'd0);
        end
        {btn_confirm, btn_mode, btn_inc} = 3'b000;
        rst_n  = 1'b1;
        m_edit = 0;
        m_idx  = 0;
        m_val  = 0;
    endtask

    // Hold a button combination long enough to be accepted, release it, and compare.
    task automatic press(input logic [2:0] b);
        int exp_sets, exp_sel, exp_val;
        n_set = 0;
        {btn_confirm, btn_mode, btn_inc} = b;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) {btn_confirm, btn_mode, btn_inc} = 3'b000;
            tick();
            if (set === 1'b1) begin
                n_set++;
                got_sel = 32'(select);
                got_val = 32'(digit_value);
            end else if (select !== 6'd0) begin
                chk("select_idle", 32'(select), 32'd0);
            end
        end
        exp_sets = 0;
        exp_sel  = 0;
        exp_val  = 0;
        if (m_edit == 0) begin
            if (b[1]) begin
                m_edit = 1;
                m_idx  = 5;
                m_val  = 0;
            end
        end else if (b[2] || b[1]) begin
            exp_sets = 1;
            exp_sel  = 1 << m_idx;
            exp_val  = m_val;
            if (b[2] || m_idx == 0) begin
                m_edit = 0;
            end else begin
                m_idx = m_idx - 1;
                m_val = 0;
            end
        end else if (b[0]) begin
            m_val = (m_val == maxes[m_idx]) ? 0 : m_val + 1;
        end
        chk("set_count", 32'(n_set), 32'(exp_sets));
        if (exp_sets == 1) begin
            chk("commit_select", 32'(got_sel), 32'(exp_sel));
            chk("commit_value", 32'(got_val), 32'(exp_val));
        end
        chk_outputs("after_press");
    endtask

    initial begin
        {btn_confirm, btn_mode, btn_inc} = 3'b000;

        // 1. Reset with buttons toggling.
        do_reset();
        tick();
        chk_outputs("reset");
        chk("reset_set", 32'(set), 32'd0);
        chk("reset_select", 32'(select), 32'd0);
        chk("reset_blink", 32'(blink), 32'd0);

        // 2. Short bursts are rejected, a long hold enters EDIT exactly once.
        for (int i = 0; i < 14; i++) begin
            btn_mode = (i < 6) ? ((i / 2) % 2 == 0) : 1'b0;
            tick();
        end
        chk("bounce_run_en", 32'(run_en), 32'd1);
        chk("bounce_idx", 32'(edit_idx), 32'd0);
        btn_mode = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("latency_early", 32'(run_en), 32'd1);
        tick();
        chk("latency_run_en", 32'(run_en), 32'd0);
        chk("latency_idx", 32'(edit_idx), 32'd5);
        chk("latency_val", 32'(digit_value), 32'd0);
        n_set = 0;
        for (int i = 0; i < 13 + 12; i++) begin
            if (i == 13) btn_mode = 1'b0;
            tick();
            if (set === 1'b1) n_set++;
        end
        chk("hold_single_press", 32'(n_set), 32'd0);
        m_edit = 1;
        m_idx  = 5;
        m_val  = 0;
        chk_outputs("hold");

        // 3. Wrap on hour tens, then commit.
        for (int i = 0; i < 4; i++) press(3'b001);
        chk("wrap_value", 32'(digit_value), 32'd1);
        press(3'b010);
        chk("wrap_commit_sel", 32'(got_sel), 32'b100000);

        // 4. Full walk.
        press(3'b100);
        press(3'b010);
        for (int d = 0; d < 6; d++) begin
            for (int j = 0; j < walk[d]; j++) press(3'b001);
            press(3'b010);
            chk("walk_sel", 32'(got_sel), 32'(6'b100000 >> d));
            chk("walk_val", 32'(got_val), 32'(walk[d]));
        end
        chk("walk_run_en", 32'(run_en), 32'd1);

        // 5. Confirm wins over simultaneous mode.
        press(3'b010);
        press(3'b010);
        press(3'b010);
        for (int j = 0; j < 4; j++) press(3'b001);
        press(3'b110);
        chk("exit_sel", 32'(got_sel), 32'b001000);
        chk("exit_val", 32'(got_val), 32'd4);
        n_set = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (set === 1'b1) n_set++;
        end
        chk("exit_no_more_set", 32'(n_set), 32'd0);

        // 6. Reset mid-edit, then blink.
        press(3'b010);
        press(3'b010);
        press(3'b010);
        press(3'b010);
        chk("mid_idx", 32'(edit_idx), 32'd2);
        do_reset();
        tick();
        chk_outputs("mid_reset");
        chk("mid_reset_select", 32'(select), 32'd0);
        btn_mode = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        for (int i = 0; i < 16; i++) begin
`ifdef STOPWATCH_SET_BLINK_EN
            chk("blink_phase", 32'(blink), 32'(i < 8));
`else
            chk("blink_off", 32'(blink), 32'd0);
`endif
            tick();
        end
        btn_mode = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        m_edit = 1;
        m_idx  = 5;
        m_val  = 0;
        chk_outputs("blink_edit");

        // Random presses against the model.
        for (int k = 0; k < 40; k++) begin
            press(3'(masks[$urandom_range(0, 5)]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
